// File: rtl/simple_mips_host_shell.sv
// simple_mips_host_shell: AXI-Lite register file, AXI4 burst load/store of a local word memory
// and start/halt sequencing of the attached MIPS core.
module simple_mips_host_shell #(
    parameter int C_S_ADDR_WIDTH = 5,
    parameter int C_M_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic S_ACLK,
    input  logic S_ARESET,
    input  logic S_AWVALID,
    output logic S_AWREADY,
    input  logic [C_S_ADDR_WIDTH-1:0] S_AWADDR,
    input  logic [2:0] S_AWPROT,
    input  logic S_WVALID,
    output logic S_WREADY,
    input  logic [C_DATA_WIDTH-1:0] S_WDATA,
    input  logic [3:0] S_WSTRB,
    output logic S_BVALID,
    input  logic S_BREADY,
    output logic [1:0] S_BRESP,
    input  logic S_ARVALID,
    output logic S_ARREADY,
    input  logic [C_S_ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [2:0] S_ARPROT,
    output logic S_RVALID,
    input  logic S_RREADY,
    output logic [C_DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0] S_RRESP,
    output logic M_AWVALID,
    input  logic M_AWREADY,
    output logic [C_M_ADDR_WIDTH-1:0] M_AWADDR,
    output logic [7:0] M_AWLEN,
    output logic [2:0] M_AWSIZE,
    output logic [1:0] M_AWBURST,
    output logic [3:0] M_AWCACHE,
    output logic M_AWID,
    output logic M_AWLOCK,
    output logic [2:0] M_AWPROT,
    output logic [3:0] M_AWQOS,
    output logic M_AWUSER,
    output logic M_WVALID,
    input  logic M_WREADY,
    output logic [C_DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0] M_WSTRB,
    output logic M_WLAST,
    output logic M_WUSER,
    input  logic M_BVALID,
    output logic M_BREADY,
    input  logic [1:0] M_BRESP,
    input  logic M_BID,
    input  logic M_BUSER,
    output logic M_ARVALID,
    input  logic M_ARREADY,
    output logic [C_M_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0] M_ARLEN,
    output logic [2:0] M_ARSIZE,
    output logic [1:0] M_ARBURST,
    output logic [3:0] M_ARCACHE,
    output logic M_ARID,
    output logic M_ARLOCK,
    output logic [2:0] M_ARPROT,
    output logic [3:0] M_ARQOS,
    output logic M_ARUSER,
    input  logic M_RVALID,
    output logic M_RREADY,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0] M_RRESP,
    input  logic M_RLAST,
    input  logic M_RID,
    input  logic M_RUSER,
    output logic CORE_START,
    input  logic CORE_HALT,
    input  logic [7:0] CORE_MEM_ADDR,
    input  logic CORE_MEM_WE,
    input  logic [C_DATA_WIDTH-1:0] CORE_MEM_WDATA,
    output logic [C_DATA_WIDTH-1:0] CORE_MEM_RDATA,
    output logic PROC_DONE
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, CORE_RUN, WADDR, WDATA, WRESP} state_t;
    state_t state, state_n;
    logic [C_DATA_WIDTH-1:0] mode_q, size_q, run_q, ddr_addr, r_data, rd_reg, mem_q;
    logic [C_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic aw_rdy, b_vld, ar_rdy, r_vld, core_start, pf, wdone, xfer_done, resp_err, proc_done;
    logic wr_fire, ar_fire, start, rfire, wfire, bfire, wlast;
    logic [AW:0] k, size_eff;
    logic [AW-1:0] rd_addr;
    logic [2:0] wsel;
    logic unused_ok;
    assign unused_ok = ^{S_AWPROT, S_ARPROT, S_WSTRB, S_AWADDR[1:0], S_ARADDR[1:0], M_BID, M_BUSER, M_RID, M_RUSER};
    assign wsel = S_AWADDR[4:2];
    assign wr_fire = aw_rdy & S_AWVALID & S_WVALID;
    assign ar_fire = ar_rdy & S_ARVALID;
    assign start = wr_fire && wsel == 3'd3 && S_WDATA[0] && state == IDLE && size_q != '0;
    assign size_eff = (size_q > C_DATA_WIDTH'(MEM_WORDS)) ? (AW+1)'(MEM_WORDS) : size_q[AW:0];
    assign wlast = k == size_eff - 1'b1;
    assign rfire = state == RDATA && M_RVALID;
    assign wfire = M_WVALID & M_WREADY;
    assign bfire = state == WRESP && M_BVALID;
    assign rd_reg = (S_ARADDR[4:2] == 3'd0) ? mode_q :
                    (S_ARADDR[4:2] == 3'd1) ? ddr_addr :
                    (S_ARADDR[4:2] == 3'd2) ? size_q :
                    (S_ARADDR[4:2] == 3'd3) ? run_q :
                    (S_ARADDR[4:2] == 3'd4) ? C_DATA_WIDTH'({resp_err, proc_done, xfer_done, state != IDLE}) : '0;
    assign {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID} = {aw_rdy, aw_rdy, b_vld, ar_rdy, r_vld};
    assign {S_BRESP, S_RRESP, S_RDATA} = {2'b00, 2'b00, r_data};
    assign {M_AWADDR, M_ARADDR} = {ddr_addr, ddr_addr};
    assign {M_AWLEN, M_ARLEN} = {2{8'(size_eff - 1'b1)}};
    assign {M_AWSIZE, M_ARSIZE, M_AWBURST, M_ARBURST, M_AWCACHE, M_ARCACHE} = {3'b010, 3'b010, 2'b01, 2'b01, 4'b0010, 4'b0010};
    assign {M_AWID, M_ARID, M_AWLOCK, M_ARLOCK, M_AWPROT, M_ARPROT, M_AWQOS, M_ARQOS} = '0;
    assign {M_AWUSER, M_ARUSER, M_WUSER} = '0;
    assign {M_WDATA, M_WSTRB, M_WLAST} = {mem_q, 4'hF, wlast};
    assign {CORE_MEM_RDATA, CORE_START, PROC_DONE} = {mem_q, core_start, proc_done};
    always_comb begin
        state_n = state;
        {M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY} = '0;
        rd_addr = AW'(CORE_MEM_ADDR);
        case (state)
            IDLE: state_n = start ? (mode_q[0] ? RADDR : WADDR) : IDLE;
            RADDR: begin
                M_ARVALID = 1'b1;
                state_n = M_ARREADY ? RDATA : RADDR;
            end
            RDATA: begin
                M_RREADY = 1'b1;
                state_n = (M_RVALID && M_RLAST) ? CORE_RUN : RDATA;
            end
            CORE_RUN: state_n = CORE_HALT ? IDLE : CORE_RUN;
            // W beats may run ahead of the AW handshake; the read port prefetches the next word
            WADDR: begin
                M_AWVALID = 1'b1;
                M_WVALID = pf & ~wdone;
                rd_addr = k[AW-1:0] + AW'(wfire);
                state_n = M_AWREADY ? WDATA : WADDR;
            end
            WDATA: begin
                M_WVALID = pf & ~wdone;
                rd_addr = k[AW-1:0] + AW'(wfire);
                state_n = (wdone || (wfire && wlast)) ? WRESP : WDATA;
            end
            WRESP: begin
                M_BREADY = 1'b1;
                state_n = M_BVALID ? IDLE : WRESP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge S_ACLK) begin
        if (rfire && !k[AW]) mem[k[AW-1:0]] <= M_RDATA;
        else if (state == CORE_RUN && CORE_MEM_WE) mem[AW'(CORE_MEM_ADDR)] <= CORE_MEM_WDATA;
        mem_q <= mem[rd_addr];
    end
    always_ff @(posedge S_ACLK or posedge S_ARESET) begin
        if (S_ARESET) begin
            state <= IDLE;
            {aw_rdy, b_vld, ar_rdy, r_vld, core_start, pf, wdone, xfer_done, resp_err, proc_done} <= '0;
            {mode_q, size_q, run_q, ddr_addr, r_data} <= '0;
            k <= '0;
        end else begin
            state <= state_n;
            aw_rdy <= S_AWVALID & S_WVALID & ~b_vld & ~aw_rdy;
            b_vld <= wr_fire | (b_vld & ~S_BREADY);
            ar_rdy <= S_ARVALID & ~ar_rdy & ~r_vld;
            r_vld <= ar_fire | (r_vld & ~S_RREADY);
            if (ar_fire) r_data <= rd_reg;
            core_start <= rfire & M_RLAST;
            pf <= state == WADDR || state == WDATA;
            if (wr_fire && wsel == 3'd0) mode_q <= S_WDATA;
            if (wr_fire && wsel == 3'd1) ddr_addr <= S_WDATA;
            if (wr_fire && wsel == 3'd2) size_q <= S_WDATA;
            if (wr_fire && wsel == 3'd3) run_q <= S_WDATA;
            if (start) begin
                k <= '0;
                {wdone, xfer_done, resp_err} <= '0;
                if (mode_q[0]) proc_done <= 1'b0;
            end
            // beats past the end of local memory are accepted but dropped
            if (rfire) begin
                if (!k[AW]) k <= k + 1'b1;
                if (M_RRESP != 2'b00) resp_err <= 1'b1;
                if (M_RLAST) xfer_done <= 1'b1;
            end
            if (wfire) begin
                k <= k + 1'b1;
                if (wlast) wdone <= 1'b1;
            end
            if (state == CORE_RUN && CORE_HALT) proc_done <= 1'b1;
            if (bfire) begin
                xfer_done <= 1'b1;
                if (M_BRESP != 2'b00) resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_simple_mips_host_shell.sv
// tb_simple_mips_host_shell: randomized load/run/store scenarios checked against a word-array model
module tb_simple_mips_host_shell;
    logic S_ACLK = 0, S_ARESET = 1;
    logic S_AWVALID = 0, S_AWREADY, S_WVALID = 0, S_WREADY, S_BVALID, S_BREADY = 1;
    logic [4:0] S_AWADDR = 0, S_ARADDR = 0;
    logic [2:0] S_AWPROT = 0, S_ARPROT = 0;
    logic [31:0] S_WDATA = 0, S_RDATA;
    logic [3:0] S_WSTRB = 4'hF;
    logic [1:0] S_BRESP, S_RRESP;
    logic S_ARVALID = 0, S_ARREADY, S_RVALID, S_RREADY = 1;
    logic M_AWVALID, M_AWREADY = 0, M_WVALID, M_WREADY = 0, M_WLAST, M_WUSER;
    logic [31:0] M_AWADDR, M_ARADDR, M_WDATA;
    logic [7:0] M_AWLEN, M_ARLEN;
    logic [2:0] M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
    logic [1:0] M_AWBURST, M_ARBURST;
    logic [3:0] M_AWCACHE, M_ARCACHE, M_AWQOS, M_ARQOS, M_WSTRB;
    logic M_AWID, M_ARID, M_AWLOCK, M_ARLOCK, M_AWUSER, M_ARUSER;
    logic M_BVALID = 0, M_BREADY, M_BID = 0, M_BUSER = 0;
    logic [1:0] M_BRESP = 0, M_RRESP = 0;
    logic M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY, M_RLAST = 0, M_RID = 0, M_RUSER = 0;
    logic [31:0] M_RDATA = 0;
    logic CORE_START, CORE_HALT = 0, CORE_MEM_WE = 0, PROC_DONE;
    logic [7:0] CORE_MEM_ADDR = 0;
    logic [31:0] CORE_MEM_WDATA = 0, CORE_MEM_RDATA;

    simple_mips_host_shell dut (
        .S_ACLK(S_ACLK), .S_ARESET(S_ARESET),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
        .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWCACHE(M_AWCACHE), .M_AWID(M_AWID),
        .M_AWLOCK(M_AWLOCK), .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWUSER(M_AWUSER),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_WLAST(M_WLAST), .M_WUSER(M_WUSER),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP), .M_BID(M_BID), .M_BUSER(M_BUSER),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
        .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARCACHE(M_ARCACHE), .M_ARID(M_ARID),
        .M_ARLOCK(M_ARLOCK), .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARUSER(M_ARUSER),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
        .M_RLAST(M_RLAST), .M_RID(M_RID), .M_RUSER(M_RUSER),
        .CORE_START(CORE_START), .CORE_HALT(CORE_HALT), .CORE_MEM_ADDR(CORE_MEM_ADDR),
        .CORE_MEM_WE(CORE_MEM_WE), .CORE_MEM_WDATA(CORE_MEM_WDATA), .CORE_MEM_RDATA(CORE_MEM_RDATA),
        .PROC_DONE(PROC_DONE)
    );

    always #5 S_ACLK = ~S_ACLK;

    int checks = 0, failures = 0, start_cnt = 0;
    logic [31:0] exp_mem [256];
    logic [31:0] img [300];

    always @(negedge S_ACLK) if (CORE_START) start_cnt++;

    task automatic lite_write(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        S_AWADDR = a; S_WDATA = d; S_AWVALID = 1; S_WVALID = 1;
        while (!S_AWREADY && n < 20) begin @(negedge S_ACLK); n++; end
        if (!S_AWREADY) begin checks++; failures++; $display("FAIL lite_write_timeout addr=%h got=0 exp=1", a); end
        @(posedge S_ACLK); #1;
        S_AWVALID = 0; S_WVALID = 0;
        @(negedge S_ACLK);
    endtask

    task automatic lite_read(input logic [4:0] a, output logic [31:0] d);
        int n = 0;
        S_ARADDR = a; S_ARVALID = 1;
        while (!S_ARREADY && n < 20) begin @(negedge S_ACLK); n++; end
        if (!S_ARREADY) begin checks++; failures++; $display("FAIL lite_read_timeout addr=%h got=0 exp=1", a); end
        @(posedge S_ACLK); #1;
        S_ARVALID = 0;
        @(negedge S_ACLK);
        d = S_RVALID ? S_RDATA : 32'hBAD0BAD0;
    endtask

    task automatic core_read(input int a, output logic [31:0] d);
        CORE_MEM_ADDR = 8'(a); CORE_MEM_WE = 0;
        @(negedge S_ACLK);
        d = CORE_MEM_RDATA;
    endtask

    task automatic core_write(input int a, input logic [31:0] d);
        CORE_MEM_ADDR = 8'(a); CORE_MEM_WDATA = d; CORE_MEM_WE = 1;
        @(negedge S_ACLK);
        CORE_MEM_WE = 0;
        exp_mem[a] = d;
    endtask

    // DDR-side read slave: serves n beats of img (RLAST on beat n-1), stopping early after stop_at beats
    task automatic serve_load(input int n, input int err_at, input int stop_at, output logic [31:0] araddr,
                              output logic [7:0] arlen, output logic [2:0] arsize, output logic [1:0] arburst,
                              output bit ok);
        int t = 0;
        ok = 1;
        while (!M_ARVALID && t < 50) begin @(negedge S_ACLK); t++; end
        if (!M_ARVALID) begin ok = 0; return; end
        araddr = M_ARADDR; arlen = M_ARLEN; arsize = M_ARSIZE; arburst = M_ARBURST;
        M_ARREADY = 1;
        @(posedge S_ACLK); #1;
        M_ARREADY = 0;
        for (int i = 0; i < n && i < stop_at; i++) begin
            @(negedge S_ACLK);
            if ($urandom_range(0, 3) == 0) @(negedge S_ACLK);
            M_RVALID = 1; M_RDATA = img[i]; M_RRESP = (i == err_at) ? 2'd2 : 2'd0; M_RLAST = (i == n - 1);
            if (!M_RREADY) begin ok = 0; M_RVALID = 0; return; end
            @(posedge S_ACLK); #1;
            if (i < 256) exp_mem[i] = img[i];
            M_RVALID = 0; M_RLAST = 0; M_RRESP = 0;
        end
        @(negedge S_ACLK);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        S_ARESET = 1;
        repeat (3) @(negedge S_ACLK);
        checks++;
        if ({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, CORE_START, PROC_DONE} !== 12'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, CORE_START, PROC_DONE});
        end
        S_ARESET = 0;
        @(negedge S_ACLK);
        for (int r = 0; r < 5; r++) begin
            lite_read(5'(r * 4), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", r, d); end
        end
    endtask

    task automatic test_load;
        logic [31:0] araddr, d; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; bit ok; int s0;
        for (int i = 0; i < 108; i++) img[i] = $urandom;
        img[0] = 32'h8FA40000; img[44] = 32'd22;
        lite_write(5'h00, 1); lite_write(5'h04, 32'h12340000); lite_write(5'h08, 108);
        s0 = start_cnt;
        lite_write(5'h0C, 1);
        serve_load(108, -1, 999, araddr, arlen, arsize, arburst, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL load_handshake got=%0d exp=1", ok); end
        checks++; if (araddr !== 32'h12340000) begin failures++; $display("FAIL load_araddr got=%h exp=12340000", araddr); end
        checks++; if (arlen !== 8'd107) begin failures++; $display("FAIL load_arlen got=%0d exp=107", arlen); end
        checks++; if (arsize !== 3'd2 || arburst !== 2'd1) begin failures++; $display("FAIL load_arsize_burst got=%0d/%0d exp=2/1", arsize, arburst); end
        repeat (3) @(negedge S_ACLK);
        checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL load_core_start got=%0d exp=1", start_cnt - s0); end
        lite_read(5'h10, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL load_status_running got=%h exp=3", d); end
        core_read(0, d);
        checks++; if (d !== 32'h8FA40000) begin failures++; $display("FAIL load_word0 got=%h exp=8fa40000", d); end
        core_read(44, d);
        checks++; if (d !== 32'd22) begin failures++; $display("FAIL load_word44 got=%h exp=16", d); end
        for (int j = 0; j < 6; j++) begin
            int a = (j == 0) ? 107 : $urandom_range(0, 107);
            core_read(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++; $display("FAIL load_word%0d got=%h exp=%h", a, d, exp_mem[a]); end
        end
        core_write(108, $urandom);
        core_write(50, $urandom);
        core_read(50, d);
        checks++; if (d !== exp_mem[50]) begin failures++; $display("FAIL core_write50 got=%h exp=%h", d, exp_mem[50]); end
    endtask

    task automatic test_proc_done;
        logic [31:0] d;
        CORE_HALT = 1;
        checks++; if (PROC_DONE !== 1'b0) begin failures++; $display("FAIL proc_done_early got=%b exp=0", PROC_DONE); end
        @(negedge S_ACLK);
        CORE_HALT = 0;
        checks++; if (PROC_DONE !== 1'b1) begin failures++; $display("FAIL proc_done_set got=%b exp=1", PROC_DONE); end
        lite_read(5'h10, d);
        checks++; if (d !== 32'h6) begin failures++; $display("FAIL proc_done_status got=%h exp=6", d); end
    endtask

    task automatic test_store;
        int beats = 0, aw_hs = 0, n = 0;
        logic [7:0] awlen = 0; logic [2:0] awsize = 0; logic [31:0] d;
        lite_write(5'h00, 0); lite_write(5'h04, 32'h56780000); lite_write(5'h08, 109); lite_write(5'h0C, 1);
        while (beats < 109 && n < 2000) begin
            M_WREADY = (n < 4 || $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            M_AWREADY = M_AWVALID && n >= 6 && aw_hs == 0;
            if (M_AWVALID && M_AWREADY) begin awlen = M_AWLEN; awsize = M_AWSIZE; aw_hs++;
                checks++; if (M_AWADDR !== 32'h56780000) begin failures++; $display("FAIL store_awaddr got=%h exp=56780000", M_AWADDR); end
            end
            if (M_WVALID && M_WREADY) begin
                checks++; if (M_WDATA !== exp_mem[beats] || M_WSTRB !== 4'hF) begin failures++; $display("FAIL store_beat%0d got=%h exp=%h", beats, M_WDATA, exp_mem[beats]); end
                checks++; if (M_WLAST !== (beats == 108)) begin failures++; $display("FAIL store_wlast%0d got=%b exp=%b", beats, M_WLAST, beats == 108); end
                beats++;
            end
            @(posedge S_ACLK); #1;
            M_AWREADY = 0; M_WREADY = 0;
            @(negedge S_ACLK);
            n++;
        end
        checks++; if (beats !== 109) begin failures++; $display("FAIL store_beat_count got=%0d exp=109", beats); end
        checks++; if (aw_hs !== 1 || awlen !== 8'd108 || awsize !== 3'd2) begin failures++; $display("FAIL store_aw got=%0d/%0d/%0d exp=1/108/2", aw_hs, awlen, awsize); end
        n = 0;
        while (!M_BREADY && n < 50) begin @(negedge S_ACLK); n++; end
        checks++; if (M_BREADY !== 1'b1) begin failures++; $display("FAIL store_bready got=%b exp=1", M_BREADY); end
        M_BVALID = 1; M_BRESP = 0;
        @(posedge S_ACLK); #1;
        M_BVALID = 0;
        @(negedge S_ACLK);
        checks++; if (M_BREADY !== 1'b0 || M_WVALID !== 1'b0) begin failures++; $display("FAIL store_single_b got=%b%b exp=00", M_BREADY, M_WVALID); end
        lite_read(5'h10, d);
        checks++; if (d !== 32'h6) begin failures++; $display("FAIL store_status got=%h exp=6", d); end
    endtask

    task automatic test_resp_error;
        logic [31:0] araddr, d; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; bit ok;
        for (int i = 0; i < 8; i++) img[i] = $urandom;
        lite_write(5'h00, 1); lite_write(5'h04, 32'h0000A000); lite_write(5'h08, 8); lite_write(5'h0C, 1);
        checks++; if (PROC_DONE !== 1'b0) begin failures++; $display("FAIL err_proc_done_clear got=%b exp=0", PROC_DONE); end
        serve_load(5, 2, 999, araddr, arlen, arsize, arburst, ok);
        checks++; if (ok !== 1'b1 || arlen !== 8'd7) begin failures++; $display("FAIL err_load got=%0d/%0d exp=1/7", ok, arlen); end
        lite_read(5'h10, d);
        checks++; if (d !== 32'hB) begin failures++; $display("FAIL err_status_running got=%h exp=b", d); end
        for (int a = 0; a < 7; a++) begin
            core_read(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++; $display("FAIL err_word%0d got=%h exp=%h", a, d, exp_mem[a]); end
        end
        CORE_HALT = 1; @(negedge S_ACLK); CORE_HALT = 0;
        lite_read(5'h10, d);
        checks++; if (d !== 32'hE) begin failures++; $display("FAIL err_status_done got=%h exp=e", d); end
    endtask

    task automatic test_busy_and_size0;
        logic [31:0] araddr, d; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; bit ok; int s0, stray = 0;
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        lite_write(5'h08, 4);
        s0 = start_cnt;
        lite_write(5'h0C, 1);
        lite_write(5'h0C, 1);
        serve_load(4, -1, 999, araddr, arlen, arsize, arburst, ok);
        repeat (3) @(negedge S_ACLK);
        CORE_HALT = 1; @(negedge S_ACLK); CORE_HALT = 0;
        for (int c = 0; c < 10; c++) begin @(negedge S_ACLK); stray += int'(M_ARVALID | M_AWVALID); end
        checks++; if (ok !== 1'b1 || start_cnt - s0 !== 1 || stray !== 0) begin failures++; $display("FAIL busy_single_run got=%0d/%0d/%0d exp=1/1/0", ok, start_cnt - s0, stray); end
        lite_write(5'h08, 0);
        lite_write(5'h0C, 1);
        for (int c = 0; c < 10; c++) begin @(negedge S_ACLK); stray += int'(M_ARVALID | M_AWVALID); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL size0_started got=%0d exp=0", stray); end
        lite_read(5'h10, d);
        checks++; if (d[0] !== 1'b0) begin failures++; $display("FAIL size0_busy got=%b exp=0", d[0]); end
        lite_write(5'h0C, 32'h2);
        lite_read(5'h0C, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL run_readback got=%h exp=2", d); end
    endtask

    task automatic test_clamp;
        logic [31:0] araddr, d; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; bit ok;
        for (int i = 0; i < 258; i++) img[i] = $urandom;
        lite_write(5'h08, 300);
        lite_read(5'h08, d);
        checks++; if (d !== 32'd300) begin failures++; $display("FAIL clamp_size_readback got=%0d exp=300", d); end
        lite_write(5'h0C, 1);
        serve_load(258, -1, 999, araddr, arlen, arsize, arburst, ok);
        checks++; if (ok !== 1'b1 || arlen !== 8'd255) begin failures++; $display("FAIL clamp_arlen got=%0d/%0d exp=1/255", ok, arlen); end
        for (int j = 0; j < 5; j++) begin
            int a = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 255 : $urandom_range(2, 254);
            core_read(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++; $display("FAIL clamp_word%0d got=%h exp=%h", a, d, exp_mem[a]); end
        end
        CORE_HALT = 1; @(negedge S_ACLK); CORE_HALT = 0;
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] araddr, d; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; bit ok; int s0;
        for (int i = 0; i < 16; i++) img[i] = $urandom;
        lite_write(5'h08, 16);
        lite_write(5'h0C, 1);
        serve_load(16, -1, 3, araddr, arlen, arsize, arburst, ok);
        M_RVALID = 1; M_RDATA = img[3];
        S_ARESET = 1;
        #1;
        checks++;
        if ({M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY, CORE_START, PROC_DONE} !== 7'b0) begin
            failures++; $display("FAIL midburst_reset got=%b exp=0", {M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY, CORE_START, PROC_DONE});
        end
        @(negedge S_ACLK);
        M_RVALID = 0;
        S_ARESET = 0;
        @(negedge S_ACLK);
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        lite_write(5'h00, 1); lite_write(5'h04, 32'h00C0FFE0); lite_write(5'h08, 4);
        s0 = start_cnt;
        lite_write(5'h0C, 1);
        serve_load(4, -1, 999, araddr, arlen, arsize, arburst, ok);
        repeat (2) @(negedge S_ACLK);
        checks++; if (ok !== 1'b1 || araddr !== 32'h00C0FFE0 || arlen !== 8'd3 || start_cnt - s0 !== 1) begin
            failures++; $display("FAIL rerun_load got=%0d/%h/%0d/%0d exp=1/00c0ffe0/3/1", ok, araddr, arlen, start_cnt - s0);
        end
        for (int a = 0; a < 6; a++) begin
            core_read(a, d);
            checks++; if (d !== exp_mem[a]) begin failures++; $display("FAIL rerun_word%0d got=%h exp=%h", a, d, exp_mem[a]); end
        end
        CORE_HALT = 1; @(negedge S_ACLK); CORE_HALT = 0;
        checks++; if (PROC_DONE !== 1'b1) begin failures++; $display("FAIL rerun_proc_done got=%b exp=1", PROC_DONE); end
    endtask

    initial begin
        @(negedge S_ACLK);
        test_reset();
        test_load();
        test_proc_done();
        test_store();
        test_resp_error();
        test_busy_and_size0();
        test_clamp();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
